gpr_wb_arbiter: RTL and testbench

- Sequences the single write port of the 64-bit, 32-entry GPR file (x0 hard-wired to zero) for the CPU CU/RU.
- Arbitrates writebacks from NREQ execution units (ALU, LSU, MUL/DIV) onto that port, round-robin.
- Registers the winning write for one cycle before it reaches the GPR.
- Holds a busy-register scoreboard that stalls issue on RAW/WAW hazards against in-flight writebacks.

---
 rtl/gpr_wb_arbiter.sv | 129 ++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_arbiter.sv
// Round-robin writeback arbiter, registered GPR write stage and busy-register scoreboard.
// Optional source bypass from the write stage is enabled by defining GPR_WB_BYPASS_EN.
module gpr_wb_arbiter #(
    parameter int XLEN = 64,
    parameter int NREQ = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic [NREQ-1:0]      wb_valid,
    input  logic [5*NREQ-1:0]    wb_addr,
    input  logic [XLEN*NREQ-1:0] wb_data,
    output logic [NREQ-1:0]      wb_ready,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic [4:0]           issue_rs1,
    input  logic [4:0]           issue_rs2,
    output logic                 issue_stall,
    output logic                 gpr_clk_en,
    output logic [4:0]           rd0_addr,
    output logic [XLEN-1:0]      rd0_data,
    output logic                 sb_err,
    output logic                 byp_rs1_sel,
    output logic                 byp_rs2_sel
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [4:0]      req_addr [NREQ];
    logic [XLEN-1:0] req_data [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_addr[g] = wb_addr[5*g +: 5];
        assign req_data[g] = wb_data[XLEN*g +: XLEN];
    end

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   idx;
    logic [PW:0]     sum;
    logic            xfer;
    logic [4:0]      xfer_addr;
    logic [XLEN-1:0] xfer_data;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;
    logic            src1_hz;
    logic            src2_hz;
    logic            issue_fire;

    // Scan upward from the pointer, wrapping modulo NREQ; first requester found wins.
    always_comb begin
        // NOTE: every variable gets a value before any condition so no latch is inferred.
        xfer    = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        sum     = '0;
        if (clk_en) begin
            for (int k = 0; k < NREQ; k++) begin
                sum = {1'b0, ptr} + (PW+1)'(k);
                if (sum >= (PW+1)'(NREQ))
                    sum = sum - (PW+1)'(NREQ);
                idx = sum[PW-1:0];
                if (!xfer && wb_valid[idx]) begin
                    xfer    = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
        wb_ready  = xfer ? (NREQ'(1) << gnt_idx) : '0;
        xfer_addr = req_addr[gnt_idx];
        xfer_data = req_data[gnt_idx];
    end

`ifdef GPR_WB_BYPASS_EN
    assign byp_rs1_sel = busy[issue_rs1] & gpr_clk_en & (rd0_addr == issue_rs1);
    assign byp_rs2_sel = busy[issue_rs2] & gpr_clk_en & (rd0_addr == issue_rs2);
    assign src1_hz     = busy[issue_rs1] & ~byp_rs1_sel;
    assign src2_hz     = busy[issue_rs2] & ~byp_rs2_sel;
`else
    assign byp_rs1_sel = 1'b0;
    assign byp_rs2_sel = 1'b0;
    assign src1_hz     = busy[issue_rs1];
    assign src2_hz     = busy[issue_rs2];
`endif

    // Destination is never bypassed: a pending write to rd is a WAW hazard.
    assign issue_stall = issue_valid & (~clk_en | src1_hz | src2_hz | busy[issue_rd]);
    assign issue_fire  = issue_valid & ~issue_stall & clk_en;

    // Clear is applied before set so a new producer of the retiring register stays busy.
    always_comb begin
        busy_nxt = busy;
        if (clk_en) begin
            if (gpr_clk_en)
                busy_nxt[rd0_addr] = 1'b0;
            if (issue_fire && issue_rd != 5'd0)
                busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            ptr        <= '0;
            busy       <= '0;
            gpr_clk_en <= 1'b0;
            rd0_addr   <= '0;
            rd0_data   <= '0;
            sb_err     <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (xfer)
                ptr <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            if (clk_en) begin
                if (xfer && xfer_addr != 5'd0) begin
                    gpr_clk_en <= 1'b1;
                    rd0_addr   <= xfer_addr;
                    rd0_data   <= xfer_data;
                    if (!busy[xfer_addr])
                        sb_err <= 1'b1;
                end else begin
                    gpr_clk_en <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed test plan, then random traffic
// checked against a behavioural model of the arbitration and scoreboard rules.
module tb_gpr_wb_arbiter;

    localparam int XLEN = 64;
    localparam int NREQ = 3;
`ifdef GPR_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 clk_en;
    logic [NREQ-1:0]      wb_valid;
    logic [5*NREQ-1:0]    wb_addr;
    logic [XLEN*NREQ-1:0] wb_data;
    logic [NREQ-1:0]      wb_ready;
    logic                 issue_valid;
    logic [4:0]           issue_rd, issue_rs1, issue_rs2;
    logic                 issue_stall;
    logic                 gpr_clk_en;
    logic [4:0]           rd0_addr;
    logic [XLEN-1:0]      rd0_data;
    logic                 sb_err;
    logic                 byp_rs1_sel, byp_rs2_sel;

    logic            r_v    [NREQ];
    logic [4:0]      r_addr [NREQ];
    logic [XLEN-1:0] r_data [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign wb_valid[g]            = r_v[g];
        assign wb_addr[5*g +: 5]      = r_addr[g];
        assign wb_data[XLEN*g +: XLEN] = r_data[g];
    end

    gpr_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_stall(issue_stall),
        .gpr_clk_en(gpr_clk_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data),
        .sb_err(sb_err), .byp_rs1_sel(byp_rs1_sel), .byp_rs2_sel(byp_rs2_sel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state
    bit              m_busy [32];
    int              m_ptr;
    bit              m_gce;
    logic [4:0]      m_addr;
    logic [XLEN-1:0] m_data;
    bit              m_err;
    int              m_grant;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[r]) m_busy[r] = 1'b0;
        m_ptr = 0; m_gce = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0; m_grant = -1;
    endtask

    function automatic bit src_blocked(input logic [4:0] r);
        return m_busy[r] && !(BYP && m_gce && m_addr == r);
    endfunction

    function automatic bit byp_exp(input logic [4:0] r);
        return BYP && m_busy[r] && m_gce && m_addr == r;
    endfunction

    // Compare every output at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        logic [NREQ-1:0] rdy;
        bit              stall, fire;
        int              i;
        @(negedge clk);
        m_grant = -1;
        if (clk_en)
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (m_grant < 0 && r_v[i]) m_grant = i;
            end
        rdy = '0;
        if (m_grant >= 0) rdy[m_grant] = 1'b1;
        stall = issue_valid && (!clk_en || src_blocked(issue_rs1) || src_blocked(issue_rs2)
                                || m_busy[issue_rd]);
        chk("wb_ready", wb_ready, rdy);
        chk("issue_stall", issue_stall, stall);
        chk("gpr_clk_en", gpr_clk_en, m_gce);
        chk("rd0_addr", rd0_addr, m_addr);
        chk("rd0_data", rd0_data, m_data);
        chk("sb_err", sb_err, m_err);
        chk("byp_rs1_sel", byp_rs1_sel, issue_valid ? byp_exp(issue_rs1) : byp_rs1_sel & byp_exp(issue_rs1));
        chk("byp_rs2_sel", byp_rs2_sel, issue_valid ? byp_exp(issue_rs2) : byp_rs2_sel & byp_exp(issue_rs2));
        if (clk_en) begin
            fire = issue_valid && !stall;
            if (m_grant >= 0 && r_addr[m_grant] != 0 && !m_busy[r_addr[m_grant]])
                m_err = 1'b1;
            if (m_gce) m_busy[m_addr] = 1'b0;
            if (fire && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            if (m_grant >= 0) begin
                m_ptr = (m_grant + 1) % NREQ;
                if (r_addr[m_grant] != 0) begin
                    m_gce = 1'b1; m_addr = r_addr[m_grant]; m_data = r_data[m_grant];
                end else
                    m_gce = 1'b0;
            end else
                m_gce = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        issue_valid = v; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
    endtask

    task automatic req(input int i, input bit v, input logic [4:0] a, input logic [XLEN-1:0] d);
        r_v[i] = v; r_addr[i] = a; r_data[i] = d;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_gce"}, gpr_clk_en, 1'b0);
        chk({tag, "_addr"}, rd0_addr, 5'd0);
        chk({tag, "_data"}, rd0_data, '0);
        chk({tag, "_err"}, sb_err, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1;
        issue(0, 0, 0, 0);
        for (int i = 0; i < NREQ; i++) req(i, 0, 0, 0);
        model_reset();
        #12;
        check_reset_state("reset");
        chk("reset_ready", wb_ready, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // RAW stall on x5 until the ALU writeback retires
        issue(1, 5'd5, 5'd1, 5'd2);
        #1 chk("t1_issue_free", issue_stall, 1'b0);
        cycle();
        issue(1, 5'd10, 5'd5, 5'd0);
        #1 chk("t1_raw_stall", issue_stall, 1'b1);
        cycle();
        req(0, 1, 5'd5, 64'hDEAD_BEEF);
        #1 chk("t1_grant", wb_ready, 3'b001);
        chk("t1_stall_grant", issue_stall, 1'b1);
        cycle();
        req(0, 0, 0, 0);
        chk("t1_gce", gpr_clk_en, 1'b1);
        chk("t1_addr", rd0_addr, 5'd5);
        chk("t1_data", rd0_data, 64'hDEAD_BEEF);
        chk("t1_stall_wr", issue_stall, !BYP);
        cycle();
        chk("t1_stall_after", issue_stall, BYP);
        cycle();
        issue(0, 0, 0, 0);

        rst_n = 1'b0;
        #2 check_reset_state("rst1");
        model_reset();
        rst_n = 1'b1;

        // Three simultaneous requesters: round-robin order 0,1,2
        issue(1, 5'd3, 5'd0, 5'd0); cycle();
        issue(1, 5'd4, 5'd0, 5'd0); cycle();
        issue(1, 5'd6, 5'd0, 5'd0); cycle();
        issue(0, 0, 0, 0);
        req(0, 1, 5'd3, 64'hA); req(1, 1, 5'd4, 64'hB); req(2, 1, 5'd6, 64'hC);
        #1 chk("t2_g0", wb_ready, 3'b001);
        cycle(); req(0, 0, 0, 0);
        chk("t2_g1", wb_ready, 3'b010);
        chk("t2_a3", rd0_addr, 5'd3);
        cycle(); req(1, 0, 0, 0);
        chk("t2_g2", wb_ready, 3'b100);
        chk("t2_a4", rd0_addr, 5'd4);
        cycle(); req(2, 0, 0, 0);
        chk("t2_a6", rd0_addr, 5'd6);
        chk("t2_gce", gpr_clk_en, 1'b1);

        // x0 writebacks: pointer back at 0, accepted and dropped
        req(0, 1, 5'd0, 64'h1234); req(2, 1, 5'd0, 64'h5678);
        #1 chk("t3_ptr0", wb_ready, 3'b001);
        cycle(); req(0, 0, 0, 0);
        chk("t3_gce", gpr_clk_en, 1'b0);
        chk("t3_err", sb_err, 1'b0);
        chk("t3_g2", wb_ready, 3'b100);
        cycle(); req(2, 0, 0, 0);
        chk("t3_gce2", gpr_clk_en, 1'b0);

        // Writeback to a non-busy register raises sticky sb_err
        req(1, 1, 5'd9, 64'h99);
        #1 chk("t4_g1", wb_ready, 3'b010);
        cycle(); req(1, 0, 0, 0);
        chk("t4_gce", gpr_clk_en, 1'b1);
        chk("t4_addr", rd0_addr, 5'd9);
        chk("t4_err", sb_err, 1'b1);
        repeat (3) cycle();
        chk("t4_err_sticky", sb_err, 1'b1);

        // Freeze with pending traffic, then reset mid-stage
        issue(1, 5'd12, 5'd0, 5'd0); cycle();
        issue(1, 5'd13, 5'd0, 5'd0);
        clk_en = 1'b0;
        req(0, 1, 5'd12, 64'hC0FFEE);
        for (int n = 0; n < 3; n++) begin
            #1 chk("t5_frz_ready", wb_ready, '0);
            chk("t5_frz_stall", issue_stall, 1'b1);
            cycle();
        end
        chk("t5_frz_err", sb_err, 1'b1);
        clk_en = 1'b1;
        #1 chk("t5_thaw_ready", wb_ready, 3'b001);
        cycle();
        req(0, 0, 0, 0); issue(0, 0, 0, 0);
        chk("t5_gce", gpr_clk_en, 1'b1);
        chk("t5_addr", rd0_addr, 5'd12);
        rst_n = 1'b0;
        #1 check_reset_state("t5_rst");
        model_reset();
        rst_n = 1'b1;
        issue(1, 5'd12, 5'd12, 5'd13);
        #1 chk("t5_busy_clr", issue_stall, 1'b0);
        cycle();
        issue(0, 0, 0, 0);

`ifdef GPR_WB_BYPASS_EN
        issue(1, 5'd7, 5'd0, 5'd0); cycle();
        issue(0, 0, 0, 0);
        req(1, 1, 5'd7, 64'h77); cycle();
        req(1, 0, 0, 0);
        issue(1, 5'd20, 5'd0, 5'd7);
        #1 chk("t6_byp_stall", issue_stall, 1'b0);
        chk("t6_byp_sel", byp_rs2_sel, 1'b1);
        issue(1, 5'd7, 5'd0, 5'd0);
        #1 chk("t6_waw_stall", issue_stall, 1'b1);
        cycle();
        issue(0, 0, 0, 0);
`endif

        // Random traffic against the model; requesters hold until granted
        for (int n = 0; n < 1500; n++) begin
            clk_en = ($urandom_range(0, 7) != 0);
            issue($urandom_range(0, 1), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            for (int i = 0; i < NREQ; i++)
                if (!r_v[i] && $urandom_range(0, 2) == 0)
                    req(i, 1, 5'($urandom_range(0, 7)), {$urandom, $urandom});
            cycle();
            if (m_grant >= 0) r_v[m_grant] = 1'b0;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1 check_reset_state("rnd_rst");
                model_reset();
                rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
